// File: rtl/perf_pkg.sv
// Shared definitions for the performance event counter block: FSM states and index sizing.
package perf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } perfState_e;

  // Bits needed to address the cycle counter plus numCh event channels.
  function automatic int unsigned idxWidth(input int unsigned numCh);
    return (numCh < 1) ? 1 : $clog2(numCh + 1);
  endfunction

endpackage

// File: rtl/perf_counter_cell.sv
// One event counter with sticky overflow flag; saturates or wraps on overflow.
module perf_counter_cell #(
  parameter int unsigned CNT_W    = 32,
  parameter bit          SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cntNxt_c,
  output logic             ovf
);

  logic allOnes_c;
  logic ovfNxt_c;

  // Next value is exported so the dump path can capture the value written this cycle.
  always_comb begin
    allOnes_c = &cnt;
    cntNxt_c  = cnt;
    ovfNxt_c  = ovf;
    if (clr) begin
      cntNxt_c = '0;
      ovfNxt_c = 1'b0;
    end else if (inc) begin
      if (allOnes_c) begin
        cntNxt_c = SATURATE ? cnt : '0;
        ovfNxt_c = 1'b1;
      end else begin
        cntNxt_c = cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      cnt <= cntNxt_c;
      ovf <= ovfNxt_c;
    end
  end

endmodule

// File: rtl/perf_event_counters.sv
// Multi-channel event counters plus cycle counter; freezes on halt and streams all counts
// out over a valid/ready port.
module perf_event_counters
  import perf_pkg::*;
#(
  parameter int unsigned NUM_CH   = 8,
  parameter int unsigned CNT_W    = 32,
  parameter bit          SATURATE = 1'b1,
  localparam int unsigned IDX_W   = idxWidth(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [NUM_CH-1:0] events,
  input  logic              halt,
  input  logic [IDX_W-1:0]  rd_sel,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NUM_CH:0]   ovf,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_idx,
  output logic [CNT_W-1:0]  out_data,
  output logic              done
);

  localparam int unsigned NW = NUM_CH + 1;

  perfState_e       state;
  perfState_e       stateNxt_c;
  logic             countEn_c;
  logic             accept_c;
  logic [NUM_CH:0]  incVec_c;
  logic [IDX_W-1:0] idxNxt_c;
  logic [CNT_W-1:0] dataNxt_c;
  logic [CNT_W-1:0] rdMux_c;
  logic [CNT_W-1:0] cnt    [NW];
  logic [CNT_W-1:0] cntNxt [NW];

  // Slot 0 is the cycle counter, slot i+1 is event channel i.
  assign incVec_c = {events & {NUM_CH{countEn_c}}, countEn_c};

  for (genvar g = 0; g < NW; g++) begin : gCell
    perf_counter_cell #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE)
    ) uCell (
      .clk      (clk),
      .rst      (rst),
      .inc      (incVec_c[g]),
      .clr      (clr),
      .cnt      (cnt[g]),
      .cntNxt_c (cntNxt[g]),
      .ovf      (ovf[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= stateNxt_c;
  end

  // clr overrides every other transition.
  always_comb begin
    stateNxt_c = state;
    if (clr) begin
      stateNxt_c = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (en) stateNxt_c = COUNT;
        COUNT:   if (halt) stateNxt_c = DRAIN;
        DRAIN:   if (out_ready && (out_idx == IDX_W'(NUM_CH))) stateNxt_c = DONE;
        DONE:    stateNxt_c = DONE;
        default: stateNxt_c = IDLE;
      endcase
    end
  end

  // The enabling cycle in IDLE and the halt cycle in COUNT are both counted.
  always_comb begin
    countEn_c = 1'b0;
    accept_c  = 1'b0;
    if (!clr) begin
      unique case (state)
        IDLE, COUNT: countEn_c = en;
        DRAIN:       accept_c  = out_ready;
        default:     ;
      endcase
    end
  end

  always_comb begin
    idxNxt_c = '0;
    if (stateNxt_c == DRAIN && state == DRAIN) begin
      idxNxt_c = accept_c ? out_idx + IDX_W'(1) : out_idx;
    end
  end

  // Dump word comes from the value each counter holds after this edge.
  always_comb begin
    dataNxt_c = '0;
    if (stateNxt_c == DRAIN) begin
      for (int i = 0; i < int'(NW); i++) begin
        if (idxNxt_c == IDX_W'(i)) dataNxt_c = cntNxt[i];
      end
    end
  end

  always_comb begin
    rdMux_c = '0;
    for (int i = 0; i < int'(NW); i++) begin
      if (rd_sel == IDX_W'(i)) rdMux_c = cnt[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
      rd_data   <= '0;
    end else begin
      out_valid <= (stateNxt_c == DRAIN);
      done      <= (stateNxt_c == DONE);
      out_idx   <= idxNxt_c;
      out_data  <= dataNxt_c;
      rd_data   <= rdMux_c;
    end
  end

endmodule

// File: tb/tb_perf_event_counters.sv
// Bench for perf_event_counters: a saturating and a wrapping instance share stimulus and
// are checked every cycle against a counting model of the dump protocol.
module tb_perf_event_counters;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned MAXV   = (1 << CNT_W) - 1;

  localparam int P_IDLE  = 0;
  localparam int P_COUNT = 1;
  localparam int P_DRAIN = 2;
  localparam int P_DONE  = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              en = 1'b0;
  logic              clr = 1'b0;
  logic [NUM_CH-1:0] events = '0;
  logic              halt = 1'b0;
  logic [IDX_W-1:0]  rd_sel = '0;
  logic              out_ready = 1'b0;

  logic [CNT_W-1:0]  rdS, rdW, dataS, dataW;
  logic [NUM_CH:0]   ovfS, ovfW;
  logic              vS, vW, doneS, doneW;
  logic [IDX_W-1:0]  idxS, idxW;

  perf_event_counters #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SATURATE(1'b1)) dutSat (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .events(events), .halt(halt),
    .rd_sel(rd_sel), .rd_data(rdS), .ovf(ovfS), .out_valid(vS), .out_ready(out_ready),
    .out_idx(idxS), .out_data(dataS), .done(doneS)
  );

  perf_event_counters #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SATURATE(1'b0)) dutWrap (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .events(events), .halt(halt),
    .rd_sel(rd_sel), .rd_data(rdW), .ovf(ovfW), .out_valid(vW), .out_ready(out_ready),
    .out_idx(idxW), .out_data(dataW), .done(doneW)
  );

  always #5 clk = ~clk;

  int nTests = 0;
  int nFails = 0;

  // Reference model: counts as integers, phase as a small integer.
  int unsigned mS [NUM_CH+1];
  int unsigned mW [NUM_CH+1];
  bit          oS [NUM_CH+1];
  bit          oW [NUM_CH+1];
  int          mPhase;
  int          mIdx;
  int unsigned expRdS, expRdW;

  int accIdx[$];
  int accData[$];

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nTests++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i <= NUM_CH; i++) begin
      mS[i] = 0; mW[i] = 0; oS[i] = 0; oW[i] = 0;
    end
    mPhase = P_IDLE;
    mIdx   = 0;
    expRdS = 0;
    expRdW = 0;
  endtask

  task automatic bumpAll();
    for (int i = 0; i <= NUM_CH; i++) begin
      if (i == 0 || events[i-1]) begin
        if (mS[i] == MAXV) oS[i] = 1; else mS[i] = mS[i] + 1;
        if (mW[i] == MAXV) begin oW[i] = 1; mW[i] = 0; end else mW[i] = mW[i] + 1;
      end
    end
  endtask

  // Applies the inputs present at a rising edge to the model.
  task automatic modelEdge();
    int sel;
    sel    = int'(rd_sel);
    expRdS = (sel <= NUM_CH) ? mS[sel] : 0;
    expRdW = (sel <= NUM_CH) ? mW[sel] : 0;
    if (clr) begin
      for (int i = 0; i <= NUM_CH; i++) begin
        mS[i] = 0; mW[i] = 0; oS[i] = 0; oW[i] = 0;
      end
      mPhase = P_IDLE;
      mIdx   = 0;
    end else if (mPhase == P_IDLE || mPhase == P_COUNT) begin
      bit toDrain;
      toDrain = (mPhase == P_COUNT) && halt;
      if (en) begin
        bumpAll();
        if (mPhase == P_IDLE) mPhase = P_COUNT;
      end
      if (toDrain) begin
        mPhase = P_DRAIN;
        mIdx   = 0;
      end
    end else if (mPhase == P_DRAIN) begin
      if (out_ready) begin
        if (mIdx == NUM_CH) mPhase = P_DONE;
        else mIdx++;
      end
    end
  endtask

  task automatic checkAll();
    logic [NUM_CH:0] eoS, eoW;
    bit dr;
    for (int i = 0; i <= NUM_CH; i++) begin
      eoS[i] = oS[i];
      eoW[i] = oW[i];
    end
    dr = (mPhase == P_DRAIN);
    checkEq("rdSat", 64'(rdS), 64'(expRdS));
    checkEq("rdWrap", 64'(rdW), 64'(expRdW));
    checkEq("ovfSat", 64'(ovfS), 64'(eoS));
    checkEq("ovfWrap", 64'(ovfW), 64'(eoW));
    checkEq("validSat", 64'(vS), 64'(dr));
    checkEq("validWrap", 64'(vW), 64'(dr));
    checkEq("idxSat", 64'(idxS), dr ? 64'(mIdx) : 64'd0);
    checkEq("idxWrap", 64'(idxW), dr ? 64'(mIdx) : 64'd0);
    checkEq("dataSat", 64'(dataS), dr ? 64'(mS[mIdx]) : 64'd0);
    checkEq("dataWrap", 64'(dataW), dr ? 64'(mW[mIdx]) : 64'd0);
    checkEq("doneSat", 64'(doneS), 64'(mPhase == P_DONE));
    checkEq("doneWrap", 64'(doneW), 64'(mPhase == P_DONE));
  endtask

  task automatic cycle();
    if (vS && out_ready) begin
      accIdx.push_back(int'(idxS));
      accData.push_back(int'(dataS));
    end
    @(posedge clk);
    if (rst) modelEdge();
    #1;
    checkAll();
  endtask

  task automatic doClr();
    clr = 1'b1; halt = 1'b0; en = 1'b0;
    cycle();
    clr = 1'b0;
  endtask

  // pat 0: always ready, 1: ready 1,0,0 repeating, 2: random ready.
  task automatic runDrain(input int pat);
    accIdx.delete();
    accData.delete();
    halt = 1'b0;
    for (int k = 0; k < 200 && mPhase != P_DONE; k++) begin
      case (pat)
        0:       out_ready = 1'b1;
        1:       out_ready = (k % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      cycle();
    end
    out_ready = 1'b0;
    checkEq("drainDone", 64'(doneS), 64'd1);
    checkEq("drainWords", 64'(accIdx.size()), 64'(NUM_CH + 1));
    for (int i = 0; i < accIdx.size(); i++) checkEq("drainOrder", 64'(accIdx[i]), 64'(i));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    modelReset();
    // Reset held for three cycles.
    for (int i = 0; i < 3; i++) cycle();
    rst = 1'b1;

    // Ten counted cycles of event 0, then the halt cycle.
    en = 1'b1; events = 8'h01;
    for (int i = 0; i < 10; i++) cycle();
    halt = 1'b1;
    cycle();
    checkEq("t1Idx0Data", 64'(dataS), 64'd11);
    runDrain(0);
    for (int i = 0; i < accData.size(); i++)
      checkEq("t1Word", 64'(accData[i]), (i < 2) ? 64'd11 : 64'd0);

    // 300 counted cycles on channel 2: saturating vs wrapping.
    doClr();
    en = 1'b1; events = 8'h04;
    for (int i = 0; i < 299; i++) cycle();
    halt = 1'b1;
    cycle();
    halt = 1'b0; en = 1'b0; events = '0; rd_sel = 4'd3;
    cycle();
    checkEq("t2SatCh2", 64'(rdS), 64'hFF);
    checkEq("t2WrapCh2", 64'(rdW), 64'd44);
    checkEq("t2SatOvf3", 64'(ovfS[3]), 64'd1);
    checkEq("t2WrapOvf3", 64'(ovfW[3]), 64'd1);
    runDrain(2);

    // Random counting, stalled dump with ready 1,0,0.
    doClr();
    en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      events = 8'($urandom);
      cycle();
    end
    halt = 1'b1;
    cycle();
    runDrain(1);

    // Five paused cycles out of twenty with every event asserted.
    doClr();
    events = 8'hFF;
    for (int i = 0; i < 20; i++) begin
      en   = !(i == 3 || i == 6 || i == 9 || i == 12 || i == 15);
      halt = (i == 19);
      cycle();
    end
    halt = 1'b0; en = 1'b0;
    for (int c = 1; c <= NUM_CH; c++) begin
      rd_sel = IDX_W'(c);
      cycle();
      checkEq("t4Ch15", 64'(rdS), 64'd15);
    end
    runDrain(0);

    // clr together with halt wins; no dump follows.
    doClr();
    en = 1'b1; events = 8'($urandom);
    for (int i = 0; i < 6; i++) cycle();
    clr = 1'b1; halt = 1'b1;
    cycle();
    clr = 1'b0; halt = 1'b0; en = 1'b0; out_ready = 1'b1; rd_sel = '0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checkEq("t5NoValid", 64'(vS), 64'd0);
    end
    checkEq("t5CycleZero", 64'(rdS), 64'd0);

    // Asynchronous reset while the dump sits at word 3.
    en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      events = 8'($urandom);
      cycle();
    end
    halt = 1'b1;
    cycle();
    halt = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 20 && mIdx != 3; k++) cycle();
    out_ready = 1'b0;
    checkEq("t6AtIdx3", 64'(idxS), 64'd3);
    #3;
    rst = 1'b0;
    #1;
    modelReset();
    checkEq("t6ValidLow", 64'(vS), 64'd0);
    checkEq("t6RdZero", 64'(rdW), 64'd0);
    checkAll();
    cycle();
    rst = 1'b1; en = 1'b1; rd_sel = '0; events = '0;
    for (int i = 0; i < 6; i++) cycle();

    // Randomized mix including clr, halt and out-of-range reads.
    for (int i = 0; i < 600; i++) begin
      en        = ($urandom_range(0, 3) != 0);
      events    = 8'($urandom);
      halt      = ($urandom_range(0, 15) == 0);
      clr       = ($urandom_range(0, 79) == 0);
      out_ready = 1'($urandom_range(0, 1));
      rd_sel    = IDX_W'($urandom_range(0, 15));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFails);
    $finish;
  end

endmodule
